// File: rtl/booth_pkg.sv
// Shared constants, Booth digit encoding and triplet decoder for booth_multiplier.
package booth_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned NUM_PP = 8;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  // Radix-4 Booth recoding of one {b[2i+1], b[2i], b[2i-1]} triplet.
  function automatic booth_digit_t booth_decode(input logic [2:0] trip);
    booth_digit_t digit;
    case (trip)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth partial-product generator: selects 0, +A, +2A, ~A or ~2A (sign-extended,
// unshifted); the +1 that completes a negation is returned separately as neg.
module booth_pp_gen
  import booth_pkg::*;
(
  input  logic [2:0]        triplet,
  input  logic [OP_W-1:0]   multiplicand,
  output logic [PROD_W-1:0] pp,
  output logic              neg
);

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] a_dbl;
  booth_digit_t      digit;

  assign a_ext = {{(PROD_W - OP_W){multiplicand[OP_W-1]}}, multiplicand};
  assign a_dbl = {a_ext[PROD_W-2:0], 1'b0};
  assign digit = booth_decode(triplet);

  // Select the partial product magnitude and negation for this digit.
  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (digit)
      POS1: pp = a_ext;
      POS2: pp = a_dbl;
      NEG1: begin
        pp  = ~a_ext;
        neg = 1'b1;
      end
      NEG2: begin
        pp  = ~a_dbl;
        neg = 1'b1;
      end
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Radix-4 Booth 16x16 signed multiplier, one product per cycle, no handshake.
// BOOTH_PIPE_EN defined: partial sums registered, latency 2.
// BOOTH_PIPE_EN undefined: single stage into the product register, latency 1.
module booth_multiplier
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]   multiplier,
  output logic [PROD_W-1:0] product
);

  // Implicit zero below bit 0 so triplet i is mult_ext[2i+2:2i].
  logic [OP_W:0]     mult_ext;
  logic [2:0]        triplet [NUM_PP];
  logic [PROD_W-1:0] pp_raw  [NUM_PP];
  logic              pp_neg  [NUM_PP];
  logic [PROD_W-1:0] pp_sh   [NUM_PP];
  logic [PROD_W-1:0] neg_sh  [NUM_PP];

  logic [PROD_W-1:0] sum_lo;
  logic [PROD_W-1:0] sum_hi;
  logic [PROD_W-1:0] final_sum;
  logic [PROD_W-1:0] product_q;

  assign mult_ext = {multiplier, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    assign triplet[i] = mult_ext[2*i+2 -: 3];

    booth_pp_gen u_pp_gen (
      .triplet      (triplet[i]),
      .multiplicand (multiplicand),
      .pp           (pp_raw[i]),
      .neg          (pp_neg[i])
    );

    assign pp_sh[i]  = pp_raw[i] << (2 * i);
    assign neg_sh[i] = {{(PROD_W - 1){1'b0}}, pp_neg[i]} << (2 * i);
  end

  // Reduce PP0..3 and PP4..7 into two partial sums, folding in the negate carries.
  always_comb begin
    sum_lo = '0;
    sum_hi = '0;
    for (int i = 0; i < NUM_PP / 2; i++) begin
      sum_lo = sum_lo + pp_sh[i] + neg_sh[i];
      sum_hi = sum_hi + pp_sh[i + NUM_PP/2] + neg_sh[i + NUM_PP/2];
    end
  end

`ifdef BOOTH_PIPE_EN
  logic [PROD_W-1:0] sum_lo_q;
  logic [PROD_W-1:0] sum_hi_q;

  // Stage 1 register: hold the two partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_lo_q <= '0;
      sum_hi_q <= '0;
    end else begin
      sum_lo_q <= sum_lo;
      sum_hi_q <= sum_hi;
    end
  end

  assign final_sum = sum_lo_q + sum_hi_q;
`else
  assign final_sum = sum_lo + sum_hi;
`endif

  // Output register: final modulo-2^32 sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
    end else begin
      product_q <= final_sum;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier against an integer-multiply reference.
// Honours BOOTH_PIPE_EN for the expected latency.
module tb_booth_multiplier;

`ifdef BOOTH_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] product;

  int n_tests;
  int n_fail;

  // Products of pairs sampled since the last reset, oldest first.
  logic [31:0] hist[$];

  booth_multiplier dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got time %0t required < 2000000", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 32'(p);
  endfunction

  function automatic logic [15:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'hffff;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Apply one pair across a rising edge; return what product must read just after it.
  task automatic drive_cycle(input logic [15:0] a, input logic [15:0] b,
                             output logic [31:0] exp_p);
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    hist.push_back(ref_mul(a, b));
    while (hist.size() > LAT) void'(hist.pop_front());
    #1;
    if (hist.size() >= LAT) exp_p = hist[hist.size() - LAT];
    else exp_p = 32'h0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    multiplicand = 16'h0;
    multiplier   = 16'h0;
    #3;
    n_tests++;
    if (product !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_initial: product=%h required=%h", product, 32'h0);
    end
    multiplicand = 16'h1234;
    multiplier   = 16'h0567;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (product !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held: product=%h required=%h", product, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
  endtask

  task automatic test_directed();
    logic [15:0] da  [7] = '{16'd0, 16'd100, 16'd90, 16'd85, 16'hfffd, 16'h8000, 16'h7fff};
    logic [15:0] db  [7] = '{16'd5, 16'd12, 16'd4, 16'd30, 16'd7, 16'h8000, 16'hffff};
    logic [31:0] dexp[7] = '{32'd0, 32'd1200, 32'd360, 32'd2550, 32'hffff_ffeb,
                             32'h4000_0000, 32'hffff_8001};
    logic [31:0] e;
    for (int i = 0; i < 7; i++) begin
      repeat (LAT) drive_cycle(da[i], db[i], e);
      n_tests++;
      if (product !== dexp[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] %h*%h: product=%h required=%h",
                 i, da[i], db[i], product, dexp[i]);
      end
    end
  endtask

  task automatic test_streaming();
    logic [31:0] e;
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      drive_cycle(rand_op(), rand_op(), e);
      n_tests++;
      if (product !== e) begin
        n_fail++;
        $display("FAIL streaming[%0d]: product=%h required=%h", i, product, e);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] e;
    // Nonzero operands so a missed reset is visible.
    for (int i = 0; i < 5; i++) begin
      drive_cycle(16'(1 + $urandom_range(0, 1000)), 16'(1 + $urandom_range(0, 1000)), e);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (product !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: product=%h required=%h", product, 32'h0);
    end
    hist.delete();
    multiplicand = 16'd7;
    multiplier   = 16'd9;
    @(posedge clk);
    #1;
    n_tests++;
    if (product !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midstream_held: product=%h required=%h", product, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive_cycle(16'd123, 16'hffd3, e);  // 123 * -45
      else drive_cycle(rand_op(), rand_op(), e);
      n_tests++;
      if (product !== e) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: product=%h required=%h", i, product, e);
      end
      if (i == LAT - 1) begin
        n_tests++;
        if (product !== 32'(-5535)) begin
          n_fail++;
          $display("FAIL post_reset_first: product=%h required=%h", product, 32'(-5535));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int i = 0; i < 10000 + LAT - 1; i++) begin
      drive_cycle(rand_op(), rand_op(), e);
      n_tests++;
      if (product !== e) begin
        n_fail++;
        $display("FAIL random[%0d]: product=%h required=%h", i, product, e);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_streaming();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
